// File: rtl/pong_pkg.sv
// pong_pkg: shared enums and screen constants for the Pong blocks
package pong_pkg;
  typedef enum logic [1:0] {NONE, UP, DN} move_dir_t;
  typedef enum logic [1:0] {IDLE, BURST_UP, BURST_DN} paddle_state_t;
  localparam int sWidth = 800;
  localparam int sHeight = 600;
endpackage

// File: rtl/paddle_move_ctrl_if.sv
// paddle_move_ctrl_if: button/pixel inputs and step outputs; AI ports only with PADDLE_AI_EN
interface paddle_move_ctrl_if;
  logic BtnUp, BtnDown, UpL, DownL, Busy;
  logic [11:0] xPos, yPos;
  logic [3:0] Speed;
`ifdef PADDLE_AI_EN
  logic AiMode;
  logic [10:0] BallY, PaddleTop;
  modport master (output BtnUp, BtnDown, xPos, yPos, AiMode, BallY, PaddleTop,
                  input UpL, DownL, Speed, Busy);
  modport slave (input BtnUp, BtnDown, xPos, yPos, AiMode, BallY, PaddleTop,
                 output UpL, DownL, Speed, Busy);
`else
  modport master (output BtnUp, BtnDown, xPos, yPos, input UpL, DownL, Speed, Busy);
  modport slave (input BtnUp, BtnDown, xPos, yPos, output UpL, DownL, Speed, Busy);
`endif
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus frame-sampled debounce counter
module btn_debounce #(
  parameter int DebFrames = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic en,
  output logic level
);
  logic [1:0] sync;
  logic [3:0] cnt;
  logic diff, hit;
  assign diff = sync[1] != level;
  assign hit = diff && (cnt + 4'd1 == 4'(DebFrames));
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (en) begin
        cnt <= (diff && !hit) ? cnt + 4'd1 : '0;
        if (hit) level <= ~level;
      end
    end
endmodule

// File: rtl/paddle_move_ctrl.sv
// paddle_move_ctrl: per-frame accelerating step-burst generator for one paddle
// PADDLE_AI_EN adds AiMode/BallY/PaddleTop and an AI request source.
module paddle_move_ctrl #(
  parameter int sHeight = 600,
  parameter int oHeight = 150,
  parameter int DebFrames = 2,
  parameter int MinStep = 1,
  parameter int MaxStep = 4,
  parameter int AccelFrames = 4,
  parameter int AiDeadband = 8
) (
  input logic PixelClock,
  input logic Reset,
  paddle_move_ctrl_if.slave bus
);
  import pong_pkg::*;
  logic frame_tick, tick_en, db_up, db_dn;
  logic [3:0] speed, speed_nx, rem;
  logic [7:0] hold, hold_nx;
  move_dir_t req, btn_req, prev_req;
  paddle_state_t state;
  // Ticks landing mid-burst are dropped for both debounce and request evaluation
  assign tick_en = frame_tick && state == IDLE;
  btn_debounce #(.DebFrames(DebFrames)) u_up (
    .clk(PixelClock), .rst(Reset), .raw(bus.BtnUp), .en(tick_en), .level(db_up)
  );
  btn_debounce #(.DebFrames(DebFrames)) u_dn (
    .clk(PixelClock), .rst(Reset), .raw(bus.BtnDown), .en(tick_en), .level(db_dn)
  );
  assign btn_req = (db_up && !db_dn) ? UP : (db_dn && !db_up) ? DN : NONE;
`ifdef PADDLE_AI_EN
  logic [11:0] centre, ball;
  move_dir_t ai_req;
  assign centre = {1'b0, bus.PaddleTop} + 12'(oHeight / 2);
  assign ball = {1'b0, bus.BallY};
  assign ai_req = (ball < centre - 12'(AiDeadband)) ? DN :
                  (ball > centre + 12'(AiDeadband)) ? UP : NONE;
  assign req = bus.AiMode ? ai_req : btn_req;
`else
  assign req = btn_req;
`endif
  always_comb begin
    speed_nx = 4'(MinStep);
    hold_nx = '0;
    if (req != NONE && req == prev_req && speed < 4'(MaxStep)) begin
      hold_nx = hold + 8'd1;
      speed_nx = (hold_nx == 8'(AccelFrames)) ? speed + 4'd1 : speed;
      hold_nx = (hold_nx == 8'(AccelFrames)) ? '0 : hold_nx;
    end else if (req != NONE && req == prev_req) begin
      speed_nx = speed;
    end
  end
  always_ff @(posedge PixelClock)
    if (Reset) begin
      frame_tick <= 1'b0;
      state <= IDLE;
      rem <= '0;
      speed <= 4'(MinStep);
      hold <= '0;
      prev_req <= NONE;
    end else begin
      frame_tick <= bus.xPos == 12'd0 && bus.yPos == 12'(sHeight);
      if (tick_en) begin
        speed <= speed_nx;
        hold <= hold_nx;
        prev_req <= req;
      end
      if (state == IDLE) begin
        if (tick_en && req != NONE) begin
          state <= (req == UP) ? BURST_UP : BURST_DN;
          rem <= speed_nx;
        end
      end else begin
        rem <= rem - 4'd1;
        if (rem == 4'd1) state <= IDLE;
      end
    end
  assign bus.UpL = state == BURST_UP;
  assign bus.DownL = state == BURST_DN;
  assign bus.Busy = bus.UpL | bus.DownL;
  assign bus.Speed = speed;
endmodule

// File: tb/tb_paddle_move_ctrl.sv
// tb_paddle_move_ctrl: directed + randomized frames checked against a run-length reference model
module tb_paddle_move_ctrl;
  localparam int DEB = 2, MINS = 1, MAXS = 4, ACC = 4, HGT = 600;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  paddle_move_ctrl_if bus();
  paddle_move_ctrl #(
    .sHeight(HGT), .oHeight(150), .DebFrames(DEB), .MinStep(MINS),
    .MaxStep(MAXS), .AccelFrames(ACC), .AiDeadband(8)
  ) dut (.PixelClock(clk), .Reset(rst), .bus(bus));
  bit up_h[1024], dn_h[1024];
  int req_h[1024];
  int nf = 0, n_vec = 0, n_err = 0;
  bit ai = 0;
  int ball = 0, top = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Debounced level = value of the latest run of equal frame samples that reached DEB long
  function automatic bit deb(input bit sel_dn, input int n);
    bit d = 0, prev = 0, s;
    int run = 0;
    for (int i = 0; i < n; i++) begin
      s = sel_dn ? dn_h[i] : up_h[i];
      run = (i > 0 && s == prev) ? run + 1 : 1;
      prev = s;
      if (run == DEB) d = s;
    end
    return d;
  endfunction
  // 0 = none, 1 = up, 2 = down
  function automatic int model_req(input int n);
    bit u, d;
    int c;
    c = top + 75;
    if (ai) return (ball < c - 8) ? 2 : (ball > c + 8) ? 1 : 0;
    u = deb(0, n);
    d = deb(1, n);
    return (u && !d) ? 1 : (d && !u) ? 2 : 0;
  endfunction
  task automatic do_frame(input bit u, input bit d, input string tag);
    logic [15:0] uv, dv, bv, euv, edv;
    int r, run, spd;
    @(negedge clk);
    bus.BtnUp = u;
    bus.BtnDown = d;
    repeat (4) @(negedge clk);
    r = model_req(nf);
    up_h[nf] = u;
    dn_h[nf] = d;
    req_h[nf] = r;
    nf++;
    run = 0;
    for (int i = nf - 1; i >= 0 && req_h[i] == r; i--) run++;
    spd = (r == 0) ? MINS : ((MINS + (run - 1) / ACC > MAXS) ? MAXS : MINS + (run - 1) / ACC);
    euv = (r == 1) ? 16'(((1 << spd) - 1) << 1) : 16'd0;
    edv = (r == 2) ? 16'(((1 << spd) - 1) << 1) : 16'd0;
    bus.xPos = 12'd0;
    bus.yPos = 12'(HGT);
    uv = '0; dv = '0; bv = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      uv[i] = bus.UpL;
      dv[i] = bus.DownL;
      bv[i] = bus.Busy;
      if (i == 0) bus.xPos = 12'd1;
    end
    check({tag, "_up_pulses"}, 32'(uv), 32'(euv));
    check({tag, "_dn_pulses"}, 32'(dv), 32'(edv));
    check({tag, "_busy"}, 32'(bv), 32'(euv | edv));
    check({tag, "_speed"}, 32'(bus.Speed), 32'(spd));
  endtask
  initial begin
    bit u, d;
    bus.BtnUp = 0;
    bus.BtnDown = 0;
    bus.xPos = 12'd5;
    bus.yPos = 12'd0;
`ifdef PADDLE_AI_EN
    bus.AiMode = 0;
    bus.BallY = '0;
    bus.PaddleTop = '0;
`endif
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_upl", 32'(bus.UpL), 0);
    check("rst_downl", 32'(bus.DownL), 0);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_speed", 32'(bus.Speed), MINS);
    repeat (5) do_frame(0, 0, "idle");
    repeat (16) do_frame(1, 0, "hold_up");
    // Reset during the second cycle of a 4-step up burst
    @(negedge clk);
    repeat (4) @(negedge clk);
    bus.xPos = 12'd0;
    bus.yPos = 12'(HGT);
    @(negedge clk);
    bus.xPos = 12'd1;
    @(negedge clk);
    check("burst4_c1", 32'(bus.UpL), 1);
    @(negedge clk);
    check("burst4_c2", 32'(bus.UpL), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_upl", 32'(bus.UpL), 0);
    check("midrst_busy", 32'(bus.Busy), 0);
    check("midrst_speed", 32'(bus.Speed), MINS);
    @(negedge clk);
    check("midrst_upl2", 32'(bus.UpL), 0);
    nf = 0;
    repeat (11) do_frame(1, 0, "to_speed3");
    check("speed3_reached", 32'(bus.Speed), 3);
    repeat (4) do_frame(1, 1, "both");
    repeat (4) do_frame(1, 0, "release_dn");
    u = 0;
    d = 0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(2) == 0) u = ~u;
      if ($urandom_range(3) == 0) d = ~d;
      do_frame(u, d, "rand");
    end
`ifdef PADDLE_AI_EN
    repeat (3) do_frame(0, 0, "pre_ai");
    ai = 1;
    top = 225;
    ball = 100;
    bus.AiMode = 1;
    bus.PaddleTop = 11'd225;
    bus.BallY = 11'd100;
    repeat (6) do_frame(0, 0, "ai_dn");
    ball = 305;
    bus.BallY = 11'd305;
    repeat (3) do_frame(1, 0, "ai_dead");
    ball = 400;
    bus.BallY = 11'd400;
    repeat (3) do_frame(0, 1, "ai_up");
    ai = 0;
    bus.AiMode = 0;
    repeat (4) do_frame(0, 0, "ai_off");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/paddle_move_ctrl.md
# paddle_move_ctrl

Per-frame movement controller for one Pong paddle. Debounces the raw up/down buttons, then issues one burst of `UpL`/`DownL` step pulses per video frame into the paddle datapath. Each pulse moves the paddle Y by 1. The step count per frame accelerates while a direction is held. The block sits between the board buttons and the paddle position register, clocked by the pixel clock.

## Interface
Parameters:
- `sHeight`, 600: visible lines; frame tick fires at pixel position (0, `sHeight`).
- `oHeight`, 150: paddle height; its centre is used by AI mode.
- `DebFrames`, 2: consecutive equal frame samples needed to accept a button change (1–15).
- `MinStep`, 1: steps per frame at rest speed (1–15).
- `MaxStep`, 4: speed cap (`MinStep`–15).
- `AccelFrames`, 4: held frames per +1 speed increment (1–255).
- `AiDeadband`, 8: AI idles when |ball − centre| ≤ this value.

Ports:
- `PixelClock` in 1: sole clock.
- `Reset` in 1: synchronous, active-high.
- `BtnUp` in 1: raw button, asynchronous to video.
- `BtnDown` in 1: raw button.
- `xPos` in 12: pixel counter X.
- `yPos` in 12: pixel counter Y.
- `AiMode` in 1: selects AI source (present only with the macro).
- `BallY` in 11: ball top Y (present only with the macro).
- `PaddleTop` in 11: paddle top Y from the datapath (present only with the macro).
- `UpL` out 1: step pulse; datapath increments Y.
- `DownL` out 1: step pulse; datapath decrements Y.
- `Speed` out 4: current steps per frame.
- `Busy` out 1: burst in progress.

## Operation
- **Input sync:** `BtnUp` and `BtnDown` pass through a 2-FF synchroniser.
- **FrameTick:** registered, one cycle wide. It is high in the cycle after `xPos==0 && yPos==sHeight`, so exactly once per frame.
- **Debounce:**
  - Per button: a sample counter and a debounced level. Both update only on FrameTick.
  - Synced level ≠ debounced level: the counter increments. When it reaches `DebFrames`, the debounced level flips and the counter clears.
  - Synced level = debounced level: the counter clears.
- **Request:** evaluated on FrameTick from the debounced levels registered before the tick.
  - Up only → UP.
  - Down only → DN.
  - Both or neither → NONE.
  - With the macro and `AiMode`=1, buttons are ignored:
    - centre = `PaddleTop` + `oHeight`/2, computed at 12 bits.
    - `BallY` < centre − `AiDeadband` → DN.
    - `BallY` > centre + `AiDeadband` → UP.
    - otherwise NONE.
- **Speed:** held in a hold-frame counter and `Speed`.
  - NONE, or a direction change from the previous frame's request → `Speed`=`MinStep`, hold counter = 0.
  - Same direction → hold counter +1. When it reaches `AccelFrames` and `Speed`<`MaxStep`: `Speed`+1 and hold counter = 0.
  - At `MaxStep`, the hold counter stays saturated at 0.
  - The new `Speed` applies to the burst launched by this tick.
- **FSM states:** IDLE, BURST_UP, BURST_DN. `UpL` = (state==BURST_UP); `DownL` = (state==BURST_DN).
  - IDLE + FrameTick + UP/DN → BURST_UP/BURST_DN; remaining = new `Speed`.
  - BURST_*: each cycle remaining −1. At 1 → IDLE.
  - FrameTick during a burst is impossible (`MaxStep` ≤ 15 ≪ line period); if it occurs, it is ignored for both the burst and debounce.
- `UpL` and `DownL` are never high in the same cycle.
- The controller does not clamp position; the datapath owns the bounds.

## Timing
- Reset values: `UpL`=0, `DownL`=0, `Busy`=0, `Speed`=`MinStep`, state IDLE, debounced levels 0, counters 0, FrameTick 0.
- Reset has priority over everything. Reset mid-burst drives `UpL`/`DownL` low on the next edge.
- Burst latency: the first `UpL`/`DownL` cycle is 1 cycle after FrameTick. The burst lasts exactly `Speed` consecutive cycles. `Busy` equals `UpL|DownL`.
- Button latency: a press held from before tick k is accepted at tick k+`DebFrames`−1 and produces its first burst at tick k+`DebFrames`.
- Without the macro, the full button-to-burst path above applies. With the macro, AI requests respond at the very next FrameTick.

## Configuration
- `PADDLE_AI_EN` defined:
  - The `AiMode`, `BallY` and `PaddleTop` ports exist.
  - The centre/deadband comparator is built.
  - `AiMode`=1 overrides the buttons.
- `PADDLE_AI_EN` undefined:
  - Those ports and the comparator are absent.
  - The request comes from the buttons only.

## Structure
- Shared package `pong_pkg`:
  - `move_dir_t` enum: NONE, UP, DN.
  - `paddle_state_t` enum: IDLE, BURST_UP, BURST_DN.
  - Screen constants `sWidth`=800 and `sHeight`=600.
- One sub-module, `btn_debounce`: synchroniser plus frame-sampled counter. It is instantiated twice.

## Test plan
- Reset held 3 cycles, then released with no buttons pressed → `UpL`=`DownL`=0, `Speed`=1, no pulses over 5 frames.
- `BtnUp` held from before tick 1, `DebFrames`=2 → no pulse after ticks 1–2; after tick 3, `UpL` high exactly 1 cycle starting 1 cycle after FrameTick.
- `BtnUp` held 14 frames, `AccelFrames`=4, `MaxStep`=4 → burst lengths 1,1,1,1,2,2,2,2,3,3,3,3,4,4 after acceptance.
- Both buttons held after reaching `Speed`=3 → no pulses; `Speed` back to 1 on that tick. Releasing `BtnDown` restarts `UpL` bursts at length 1.
- `Reset` asserted on the 2nd cycle of a 4-cycle `UpL` burst → `UpL`=0 from the next edge, state IDLE.
- With `PADDLE_AI_EN`, `AiMode`=1, `PaddleTop`=225, `BallY`=100 → `DownL` bursts. With `BallY`=305 (centre 300, deadband 8) → no pulses.
